// File: rtl/universal_shift_register_pkg.sv
// Shared definitions for the universal shift register: mode encodings.
package universal_shift_register_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } usr_mode_e;

  localparam int unsigned USR_MIN_WIDTH = 2;

endpackage

// File: rtl/universal_shift_register_bit_cell.sv
// One storage bit: 4:1 mode mux built from three 2:1 muxes, reset gating, one flop.
module usr_bit_cell (
  input  logic       c,
  input  logic       re_,
  input  logic [1:0] s,
  input  logic       hold_in,
  input  logic       right_in,
  input  logic       left_in,
  input  logic       load_in,
  output logic       q,
  output logic       q_
);

  logic pair_hr_s;
  logic pair_ld_s;
  logic mux_out_s;
  logic state_d;
  logic state_q;

  usr_mux2 u_mux_hr (
    .sel (s[0]),
    .a0  (hold_in),
    .a1  (right_in),
    .y   (pair_hr_s)
  );

  usr_mux2 u_mux_ld (
    .sel (s[0]),
    .a0  (left_in),
    .a1  (load_in),
    .y   (pair_ld_s)
  );

  usr_mux2 u_mux_top (
    .sel (s[1]),
    .a0  (pair_hr_s),
    .a1  (pair_ld_s),
    .y   (mux_out_s)
  );

  // Gating with re_ makes reset synchronous and gives it priority over every mode
  always_comb begin
    state_d = mux_out_s & re_;
  end

  usr_dff_sr u_ff (
    .c (c),
    .d (state_d),
    .q (state_q)
  );

  assign q  = state_q;
  assign q_ = ~state_q;

endmodule

// File: rtl/universal_shift_register_prims.sv
// Falling-edge primitives: base D flip-flop, its sync-reset wrapper and a 2:1 mux.
module usr_dff (
  input  logic c,
  input  logic clr_,
  input  logic d,
  output logic q
);

  logic state_q;

  // Base storage element, updates on the falling edge of c
  always_ff @(negedge c or negedge clr_) begin
    if (!clr_) begin
      state_q <= 1'b0;
    end else begin
      state_q <= d;
    end
  end

  assign q = state_q;

endmodule

module usr_dff_sr (
  input  logic c,
  input  logic d,
  output logic q
);

  // Reset reaches this flop through its D input, so the async clear stays idle
  usr_dff u_dff (
    .c    (c),
    .clr_ (1'b1),
    .d    (d),
    .q    (q)
  );

endmodule

module usr_mux2 (
  input  logic sel,
  input  logic a0,
  input  logic a1,
  output logic y
);

  // Plain two-input selector
  always_comb begin
    y = a0;
    if (sel) begin
      y = a1;
    end else begin
      y = a0;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: WIDTH bit cells with hold, shift right, shift left and load.
module universal_shift_register
  import universal_shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             c,
  input  logic             re_,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] d,
  input  logic             sir,
  input  logic             sil,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_,
  output logic             sor,
  output logic             sol
);

  logic [WIDTH-1:0] right_in_s;
  logic [WIDTH-1:0] left_in_s;

  // Right neighbour feeds shift-right; the MSB takes sir. Left neighbour mirrors with sil.
  always_comb begin
    right_in_s = {sir, q[WIDTH-1:1]};
    left_in_s  = {q[WIDTH-2:0], sil};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_bit_cell u_cell (
      .c        (c),
      .re_      (re_),
      .s        (s),
      .hold_in  (q[i]),
      .right_in (right_in_s[i]),
      .left_in  (left_in_s[i]),
      .load_in  (d[i]),
      .q        (q[i]),
      .q_       (q_[i])
    );
  end

  assign sor = q[0];
  assign sol = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised and directed bench for universal_shift_register against an arithmetic reference model.
module tb_universal_shift_register;
  import universal_shift_register_pkg::*;

  localparam int W = 4;

  logic         c;
  logic         re_;
  logic [1:0]   s;
  logic [W-1:0] d;
  logic         sir;
  logic         sil;
  logic [W-1:0] q;
  logic [W-1:0] q_;
  logic         sor;
  logic         sol;

  int checks;
  int errors;
  int unsigned exp_val;

  universal_shift_register #(.WIDTH(W)) dut (
    .c   (c),
    .re_ (re_),
    .s   (s),
    .d   (d),
    .sir (sir),
    .sil (sil),
    .q   (q),
    .q_  (q_),
    .sor (sor),
    .sol (sol)
  );

  initial c = 1'b1;
  always #5 c = ~c;

  // Reference next value as plain integer arithmetic on the stored word
  function automatic int unsigned ref_next(input int unsigned cur, input logic r,
                                           input logic [1:0] m, input int unsigned dv,
                                           input logic si_r, input logic si_l);
    int unsigned full;
    full = 1 << W;
    if (!r) return 0;
    case (m)
      MODE_HOLD: return cur;
      MODE_SHR:  return cur / 2 + (si_r ? full / 2 : 0);
      MODE_SHL:  return (cur * 2 + (si_l ? 1 : 0)) % full;
      default:   return dv % full;
    endcase
  endfunction

  // Drive inputs while c is high, let one falling edge pass, advance the model
  task automatic cycle(input logic r, input logic [1:0] m, input logic [W-1:0] dv,
                       input logic si_r, input logic si_l);
    @(posedge c);
    #1;
    re_ = r; s = m; d = dv; sir = si_r; sil = si_l;
    @(negedge c);
    exp_val = ref_next(exp_val, r, m, int'(dv), si_r, si_l);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, MODE_LOAD, 4'b1010, 1'b1, 1'b1);
    checks++;
    if ({q, q_, sor, sol} !== {4'b0000, 4'b1111, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: q=%b q_=%b sor=%b sol=%b, want 0000 1111 0 0", q, q_, sor, sol);
    end
  endtask

  task automatic test_load_hold();
    cycle(1'b1, MODE_LOAD, 4'b1011, 1'b0, 1'b0);
    checks++;
    if (q !== 4'b1011) begin
      errors++;
      $display("FAIL load: q=%b want 1011", q);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, MODE_HOLD, W'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if ({q, q_} !== {4'b1011, 4'b0100}) begin
        errors++;
        $display("FAIL hold[%0d]: q=%b q_=%b want 1011 0100", i, q, q_);
      end
    end
  endtask

  task automatic test_shift_right();
    logic [W-1:0] exp_seq [4];
    logic         sir_seq [4];
    logic         sor_seq [4];
    exp_seq = '{4'b0101, 4'b1010, 4'b1101, 4'b0110};
    sir_seq = '{1'b0, 1'b1, 1'b1, 1'b0};
    sor_seq = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sor !== sor_seq[i]) begin
        errors++;
        $display("FAIL shr_sor[%0d]: sor=%b want %b", i, sor, sor_seq[i]);
      end
      cycle(1'b1, MODE_SHR, W'($urandom), sir_seq[i], 1'($urandom));
      checks++;
      if (q !== exp_seq[i]) begin
        errors++;
        $display("FAIL shr[%0d]: q=%b want %b", i, q, exp_seq[i]);
      end
    end
  endtask

  task automatic test_shift_left();
    logic [W-1:0] exp_seq [4];
    logic         sol_seq [5];
    exp_seq = '{4'b0011, 4'b0111, 4'b1111, 4'b1111};
    sol_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    cycle(1'b1, MODE_LOAD, 4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sol !== sol_seq[i]) begin
        errors++;
        $display("FAIL shl_sol[%0d]: sol=%b want %b", i, sol, sol_seq[i]);
      end
      if (i < 4) begin
        cycle(1'b1, MODE_SHL, W'($urandom), 1'($urandom), 1'b1);
        checks++;
        if (q !== exp_seq[i]) begin
          errors++;
          $display("FAIL shl[%0d]: q=%b want %b", i, q, exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_seq [3];
    logic         r_seq [3];
    exp_seq = '{4'b1111, 4'b0000, 4'b1000};
    r_seq   = '{1'b1, 1'b0, 1'b1};
    cycle(1'b1, MODE_LOAD, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(r_seq[i], MODE_SHR, 4'b0000, 1'b1, 1'b0);
      checks++;
      if (q !== exp_seq[i]) begin
        errors++;
        $display("FAIL reset_mid[%0d]: q=%b want %b", i, q, exp_seq[i]);
      end
    end
  endtask

  task automatic test_input_stability();
    cycle(1'b1, MODE_LOAD, 4'b1011, 1'b0, 1'b0);
    // c is low here: d changes must not disturb state
    d = 4'b0110;
    #2;
    checks++;
    if (q !== 4'b1011) begin
      errors++;
      $display("FAIL stable_low: q=%b want 1011", q);
    end
    @(posedge c);
    #1;
    d = 4'b0101;
    #1;
    d = 4'b1110;
    #1;
    checks++;
    if (q !== 4'b1011) begin
      errors++;
      $display("FAIL stable_high: q=%b want 1011", q);
    end
    d = 4'b0010;
    @(negedge c);
    exp_val = 32'd2;
    #1;
    checks++;
    if (q !== 4'b0010) begin
      errors++;
      $display("FAIL stable_sample: q=%b want 0010", q);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 15) != 0), 2'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if ({q, q_, sor, sol} !== {W'(exp_val), ~W'(exp_val), exp_val[0], exp_val[W-1]}) begin
        errors++;
        $display("FAIL random[%0d]: q=%b q_=%b sor=%b sol=%b, want q=%b", i, q, q_, sor, sol, W'(exp_val));
      end
    end
  endtask

  task automatic test_back_to_back();
    // Walk every mode in turn with no idle cycles, checking the full word each edge
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 2'(i % 4), W'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (q !== W'(exp_val)) begin
        errors++;
        $display("FAIL b2b[%0d]: q=%b want %b", i, q, W'(exp_val));
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_val = 0;
    re_ = 1'b0; s = MODE_HOLD; d = '0; sir = 1'b0; sil = 1'b0;
    test_reset();
    test_load_hold();
    test_shift_right();
    test_shift_left();
    test_reset_mid();
    test_input_stability();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
